// File: rtl/mdu_iterative_decoder.sv
// RV32M/RV64M decoder with an iterative shift-add multiplier and restoring divider.
// Holds the execute stage through stall until the result is ready.
module mdu_iterative_decoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic            op5,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            is_m,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [2:0]        f3;
  logic              neg;
  logic [XLEN-1:0]   b_mag;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;

  logic              accept, fast, last;
  logic              sgn_a, sgn_b, neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, fast_res;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_next, mul_prod;
  logic [XLEN-1:0]   mul_res, div_rem, div_quo, div_out, div_res;
  logic              q_bit;

  assign is_m   = (ALUOp == 2'b10) && op5 && (funct7 == 7'b0000001);
  assign stall  = start && is_m && !done;
  assign accept = start && is_m && !kill;
  assign last   = (cnt == CW'(XLEN-1));

  // Operand magnitudes, result sign and division fast-path detection
  always_comb begin
    sgn_a    = src_a[XLEN-1] && (funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11));
    sgn_b    = src_b[XLEN-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
    a_mag_in = sgn_a ? -src_a : src_a;
    b_mag_in = sgn_b ? -src_b : src_b;
    neg_in   = (funct3[2] && funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
    fast     = 1'b0;
    fast_res = '0;
    if (funct3[2]) begin
      if (src_b == '0) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? src_a : '1;
      end else if (!funct3[0] && (src_a == MIN_NEG) && (src_b == '1)) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? '0 : src_a;
      end
    end
  end

  // One multiply step, one divide step, and final sign correction
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    mul_prod  = neg ? -mul_next : mul_next;
    mul_res   = (f3[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_trial = div_shift - {1'b0, b_mag};
    q_bit     = !div_trial[XLEN];
    div_rem   = q_bit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo   = {acc[XLEN-2:0], q_bit};
    div_out   = f3[1] ? div_rem : div_quo;
    div_res   = neg ? -div_out : div_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      f3     <= '0;
      neg    <= 1'b0;
      b_mag  <= '0;
      cnt    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3    <= funct3;
            neg   <= neg_in;
            b_mag <= b_mag_in;
            acc   <= {{XLEN{1'b0}}, a_mag_in};
            cnt   <= '0;
            if (fast) begin
              result <= fast_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= funct3[2] ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= (state == MUL) ? mul_next : {div_rem, div_quo};
            cnt <= cnt + CW'(1);
            if (last) begin
              result <= (state == MUL) ? mul_res : div_res;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative_decoder.sv
// Directed self-checking bench for mdu_iterative_decoder at XLEN=32.
module tb_mdu_iterative_decoder;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ALUOp;
  logic            op5;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            start;
  logic            kill;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            is_m;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  mdu_iterative_decoder #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .op5(op5), .funct3(funct3),
    .funct7(funct7), .start(start), .kill(kill), .src_a(src_a), .src_b(src_b),
    .is_m(is_m), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one M op at a negedge and wait (bounded) for its done pulse
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input int nbusy, input bit stall0, input bit keep);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    ALUOp = 2'b10; op5 = 1'b1; funct7 = 7'b0000001;
    funct3 = f3; src_a = a; src_b = b; start = 1'b1;
    #1;
    chk({tag, "_is_m"}, 32'(is_m), 32'd1);
    chk({tag, "_stall_pre"}, 32'(stall), 32'(stall0));
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) seen = 1'b1;
      else if (busy) begin
        src_a = ~a;
        src_b = b ^ 32'h5;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(nbusy));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    if (!keep) begin
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; ALUOp = 2'b00; op5 = 1'b0;
    funct3 = 3'd0; funct7 = 7'd0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplies; the first MULHU follows with start held (back-to-back)
    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32, 1'b1, 1'b1);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 32, 1'b0, 1'b0);
    do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 32, 1'b1, 1'b0);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32, 1'b1, 1'b0);

    // Divides
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, 1'b1, 1'b0);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, 1'b1, 1'b0);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, 32, 1'b1, 1'b0);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33, 32, 1'b1, 1'b0);

    // Kill in busy cycle 10, then kill+start together in IDLE
    funct3 = 3'b000; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    chk("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    chk("kill_busy_after", 32'(busy), 32'd0);
    chk("kill_no_done", 32'(done), 32'd0);
    chk("kill_result_kept", result, 32'd2);
    @(negedge clk);
    chk("kill_idle_no_accept", 32'(busy), 32'd0);
    chk("kill_idle_no_done", 32'(done), 32'd0);
    kill = 1'b0; start = 1'b0;
    @(negedge clk);

    // Non-M op is ignored
    funct7 = 7'b0000000; start = 1'b1;
    #1;
    chk("nonm_is_m", 32'(is_m), 32'd0);
    chk("nonm_stall", 32'(stall), 32'd0);
    repeat (4) @(negedge clk);
    chk("nonm_busy", 32'(busy), 32'd0);
    chk("nonm_done", 32'(done), 32'd0);
    chk("nonm_result", result, 32'd2);
    start = 1'b0;
    @(negedge clk);

    // Division fast paths
    do_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b1, 1'b0);
    do_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1, 0, 1'b1, 1'b0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b1, 1'b0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 1'b1, 1'b0);

    // Put a nonzero value in result so the reset clear is visible
    do_op("divu_pre", 3'b101, 32'd100, 32'd7, 32'd14, 33, 32, 1'b1, 1'b0);

    // Reset in cycle 20 of a DIV, then a fresh op
    funct7 = 7'b0000001; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    for (int n = 1; n <= 20; n++) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("div_after_rst", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iterative_decoder.md
Name: mdu_iterative_decoder

Overview:
- Parametrised successor to the single-cycle ALU decoder.
- Decodes RV32M/RV64M R-type ops (funct7 = 0000001) and executes them on an iterative shift-add multiplier / restoring divider.
- Sits in the execute stage beside the main ALU.
- Holds the core via a stall output until the result is ready.

Parameters:
XLEN, 32, operand/result width (32 or 64); iteration count equals XLEN

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ALUOp  in  2  main-decoder ALU op class; 2'b10 = R/I arithmetic
op5  in  1  opcode bit 5 (1 = register-register)
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
start  in  1  execute stage holds a valid instruction (level, held while stalled)
kill  in  1  flush current op (branch/trap), synchronous
src_a  in  XLEN  rs1 value
src_b  in  XLEN  rs2 value
is_m  out  1  combinational: ALUOp==2'b10 & op5 & funct7==7'b0000001
stall  out  1  combinational: start & is_m & ~done
busy  out  1  iteration in progress
done  out  1  one-cycle pulse, result valid
result  out  XLEN  registered result, held until next accept

Behaviour:
- Reset (rst_n low at posedge, any state): state IDLE; busy, done, result and all internal registers = 0. Mid-operation reset discards the op.
- funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- State IDLE:
  - Accept when start & is_m & ~kill.
  - On accept, latch funct3, operand magnitudes and result-sign flags; go to MUL or DIV; busy=1 next cycle.
  - Division special cases go to DONE directly (fast path):
    - divisor 0: DIV/DIVU -> all ones; REM/REMU -> src_a.
    - signed overflow (src_a = most-negative, src_b = -1, DIV/REM): DIV -> src_a; REM -> 0.
- State MUL:
  - One partial-product bit per cycle, XLEN cycles.
  - 2*XLEN-bit accumulator; operands handled as unsigned magnitudes.
  - Sign correction on final cycle: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
  - MUL returns low XLEN bits; MULH* return high XLEN bits.
- State DIV:
  - Restoring division, one quotient bit per cycle, XLEN cycles, on magnitudes.
  - Quotient negated if operand signs differ (DIV); remainder takes dividend sign (REM).
  - Unsigned variants skip correction.
- State DONE:
  - busy=0, done=1 for exactly one cycle; result register updated on entry.
  - Unconditionally returns to IDLE.
  - start seen in DONE is not accepted, even if still high; the core advances on done.
- Latency:
  - Normal: accept at edge 0; busy high cycles 1..XLEN; done in cycle XLEN+1.
  - Fast path: done in cycle 1.
- Ignored inputs:
  - start while busy: ignored.
  - start with is_m=0: no accept, stall=0, outputs unchanged.
- kill:
  - In MUL/DIV: next state IDLE, busy=0, no done pulse, result unchanged.
  - In IDLE: blocks accept. kill and start together in IDLE: no accept.
  - In DONE: done still pulses; the core ignores it.
- Operand changes: src_a/src_b/funct fields may change after accept without effect.
- Width: all arithmetic modulo 2^XLEN for results; accumulator 2*XLEN bits; no X on result at any time after reset.

Test Plan:
- XLEN=32, MUL src_a=7, src_b=0xFFFFFFFD -> done exactly 33 cycles after accept, result 0xFFFFFFEB; busy high 32 cycles; stall low in the done cycle.
- src_a=src_b=0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path (each done one cycle after accept, busy never asserted):
  - DIVU 5/0 -> 0xFFFFFFFF
  - REM 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0
- Abort:
  - kill in busy cycle 10 -> busy low next cycle, no done, result keeps prior value.
  - rst_n low in cycle 20 of a DIV -> next cycle busy=0, done=0, result=0; a new op then completes correctly.
- Non-M op: ALUOp=2'b10, op5=1, funct7=0000000, start=1 -> is_m=0, stall=0, busy stays 0.
- Back-to-back MULs: second op accepted the cycle after done.
